// File: rtl/gift_ise_seq.sv
// Iterative sequencer around the GIFT rv32 ISE datapath: applies key_updstd or
// permbits_step to a latched word `count` times and returns it over valid/ready.

module gift_ise_v3 (
    input  logic [31:0] i_rs1,
    input  logic [4:0]  i_imm,
    input  logic        i_op_key_updstd,
    input  logic        i_op_permbits,
    output logic [31:0] o_rd
);

    function automatic logic [31:0] swapmove(input logic [31:0] x,
                                             input logic [31:0] mask,
                                             input logic [4:0]  n);
        logic [31:0] t;
        t = (x ^ (x >> n)) & mask;
        return x ^ t ^ (t << n);
    endfunction

    logic [31:0] w_key;
    logic [31:0] w_sm0;
    logic [31:0] w_sm1;
    logic [31:0] w_sm2;
    logic [31:0] w_sm3;
    logic [63:0] w_dbl;

    assign w_key = ((i_rs1 >> 12) & 32'h0000_000F) |
                   ((i_rs1 & 32'h0000_0FFF) << 4) |
                   ((i_rs1 >> 2)  & 32'h3FFF_0000) |
                   ((i_rs1 << 14) & 32'h0003_0000);

    assign w_sm0 = swapmove(i_rs1, 32'h0A0A_0A0A, 5'd3);
    assign w_sm1 = swapmove(w_sm0, 32'h00CC_00CC, 5'd6);
    assign w_sm2 = swapmove(w_sm1, 32'h0000_F0F0, 5'd12);
    assign w_sm3 = swapmove(w_sm2, 32'h0000_00FF, 5'd24);

    // Rotating the doubled word avoids a shift-by-32 corner when imm is zero.
    assign w_dbl = {w_sm3, w_sm3} >> i_imm;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_rd = '0;
        if (i_op_key_updstd) begin
            o_rd = w_key;
        end else if (i_op_permbits) begin
            o_rd = w_dbl[31:0];
        end
    end

endmodule

module gift_ise_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_word,
    input  logic [4:0]       req_imm,
    input  logic [CNT_W-1:0] req_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_word,
    input  logic             abort,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [4:0]       r_imm;
    logic [31:0]      w_step;

    gift_ise_v3 u_ise (
        .i_rs1           (r_acc),
        .i_imm           (r_imm),
        .i_op_key_updstd (~r_op),
        .i_op_permbits   (r_op),
        .o_rd            (w_step)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid && !abort) begin
                    w_next = (req_count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (abort || rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid && !abort) begin
                r_acc <= req_word;
                r_cnt <= req_count;
                r_op  <= req_op;
                r_imm <= req_imm;
            end else if (r_state == S_RUN) begin
                // RUN is only entered with cnt >= 1, so this never wraps.
                r_acc <= w_step;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_word  = rsp_valid ? r_acc : '0;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gift_ise_seq.sv
// Self-checking bench for gift_ise_seq: directed vector table, hand-written
// handshake/abort/reset sequences, and random requests against a software model.

module tb_gift_ise_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [31:0]      req_word;
    logic [4:0]       req_imm;
    logic [CNT_W-1:0] req_count;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_word;
    logic             abort;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    gift_ise_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_word  (req_word),
        .req_imm   (req_imm),
        .req_count (req_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_word  (rsp_word),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] word;
        logic [4:0]  imm;
        int          count;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model, straight from the step definitions.
    function automatic logic [31:0] ref_key(input logic [31:0] x);
        return ((x >> 12) & 32'hF) | ((x & 32'hFFF) << 4) |
               ((x >> 2) & 32'h3FFF0000) | ((x << 14) & 32'h00030000);
    endfunction

    function automatic logic [31:0] ref_perm(input logic [31:0] x, input int imm);
        int          sh [4] = '{3, 6, 12, 24};
        logic [31:0] mk [4] = '{32'h0A0A0A0A, 32'h00CC00CC, 32'h0000F0F0, 32'h000000FF};
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t = (x ^ (x >> sh[i])) & mk[i];
            x = x ^ t ^ (t << sh[i]);
        end
        for (int i = 0; i < imm; i++) x = {x[0], x[31:1]};
        return x;
    endfunction

    function automatic logic [31:0] ref_run(input logic op, input logic [31:0] w,
                                            input int imm, input int count);
        for (int i = 0; i < count; i++) w = op ? ref_perm(w, imm) : ref_key(w);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check latency, hold rsp_ready low for `stall` cycles,
    // then complete the handshake and check the return to IDLE.
    task automatic do_req(input string name, input logic op, input logic [31:0] word,
                          input logic [4:0] imm, input int count, input logic [31:0] exp,
                          input int stall);
        check({name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_word  = word;
        req_imm   = imm;
        req_count = CNT_W'(count);
        tick();
        req_valid = 1'b0;
        req_word  = $urandom;
        for (int k = 0; k < count; k++) begin
            check({name, " early"}, 32'(rsp_valid), 32'd0);
            tick();
        end
        check({name, " valid"}, 32'(rsp_valid), 32'd1);
        check({name, " word"}, rsp_word, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({name, " held"}, {rsp_valid, req_ready, busy}, 32'b101);
            check({name, " held word"}, rsp_word, exp);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, " idle"}, {rsp_valid, req_ready, busy}, 32'b010);
        check({name, " word0"}, rsp_word, 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"key c4",      1'b0, 32'h00000001, 5'd0,  4,  32'h00000001};
        vecs[1]  = '{"key c3",      1'b0, 32'h00000001, 5'd0,  3,  32'h00001000};
        vecs[2]  = '{"perm c0",     1'b1, 32'h12345678, 5'd9,  0,  32'h12345678};
        vecs[3]  = '{"perm ones",   1'b1, 32'hFFFFFFFF, 5'd7,  5,  32'hFFFFFFFF};
        vecs[4]  = '{"perm zero",   1'b1, 32'h00000000, 5'd7,  5,  32'h00000000};
        vecs[5]  = '{"key c1",      1'b0, 32'h00000001, 5'd0,  1,  32'h00000010};
        vecs[6]  = '{"key c1 lo",   1'b0, 32'h0000000C, 5'd3,  1,  32'h000300C0};
        vecs[7]  = '{"key c1 hi",   1'b0, 32'h80000000, 5'd0,  1,  32'h20000000};
        vecs[8]  = '{"perm b0 r4",  1'b1, 32'h00000001, 5'd4,  1,  32'h00100000};
        vecs[9]  = '{"perm b1 r0",  1'b1, 32'h00000002, 5'd0,  1,  32'h00010000};
        vecs[10] = '{"perm b0 r31", 1'b1, 32'h00000001, 5'd31, 1,  32'h02000000};
        vecs[11] = '{"key c15",     1'b0, 32'h00000001, 5'd0,  15, 32'h00001000};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_word = '0; req_imm = '0;
        req_count = '0; rsp_ready = 1'b0; abort = 1'b0;
        #12;
        check("reset outs", {req_ready, rsp_valid, busy}, 32'b100);
        check("reset word", rsp_word, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].op, vecs[i].word, vecs[i].imm,
                   vecs[i].count, vecs[i].exp, i % 3);
        end

        // Backpressure: 10 stalled cycles while a competing request is offered.
        req_valid = 1'b1; req_op = 1'b0; req_word = 32'h1; req_count = 4'd2;
        tick();
        req_word = 32'hDEADBEEF; req_count = 4'd0;
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            check("bp state", {rsp_valid, req_ready, busy}, 32'b101);
            check("bp word", rsp_word, 32'h00000100);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp release", {rsp_valid, req_ready, busy}, 32'b010);
        tick();
        check("bp no accept", {rsp_valid, busy}, 32'b00);

        // Abort in IDLE beats req_valid.
        req_valid = 1'b1; abort = 1'b1; req_count = 4'd0;
        tick();
        req_valid = 1'b0; abort = 1'b0;
        check("abort idle", {rsp_valid, req_ready, busy}, 32'b010);

        // Abort on the 5th RUN cycle of a count-15 request.
        req_valid = 1'b1; req_op = 1'b0; req_word = 32'h1; req_count = 4'd15;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("abort busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort run", {rsp_valid, req_ready, busy}, 32'b010);
        for (int k = 0; k < 15; k++) begin
            check("abort no rsp", {rsp_valid, busy}, 32'b00);
            check("abort word0", rsp_word, 32'd0);
            tick();
        end
        do_req("post abort", 1'b0, 32'h1, 5'd0, 1, 32'h00000010, 0);

        // Abort while holding a result in DONE.
        req_valid = 1'b1; req_op = 1'b1; req_word = 32'h1; req_imm = 5'd4; req_count = 4'd1;
        tick();
        req_valid = 1'b0;
        tick();
        check("done before abort", 32'(rsp_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort done", {rsp_valid, req_ready, busy}, 32'b010);
        check("abort done word", rsp_word, 32'd0);

        // Asynchronous reset between edges mid-RUN.
        req_valid = 1'b1; req_op = 1'b0; req_word = 32'h1; req_count = 4'd10;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst", {req_ready, rsp_valid, busy}, 32'b100);
        check("async rst word", rsp_word, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("post rst idle", {rsp_valid, busy}, 32'b00);
        end

        // Random requests with random response stalls.
        for (int n = 0; n < 1000; n++) begin
            logic        op;
            logic [31:0] w;
            logic [4:0]  imm;
            int          cnt;
            op  = 1'($urandom);
            w   = $urandom;
            imm = 5'($urandom);
            cnt = int'($urandom_range(0, 15));
            do_req("rand", op, w, imm, cnt, ref_run(op, w, int'(imm), cnt),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
